// File: rtl/axi4_lite_register_module.sv
// AXI4-Lite slave register file for the accelerator configuration.
// Word map (index = addr[6:2]): 0..17 bias_k (R/W), 18 control (R/W),
// 19 status (read-only, live input), 20..31 unmapped (reads 0, writes dropped).
// Every response is OKAY. Each register drives its own output port directly.
//
// Handshake contract (both channels): a beat transfers on the rising edge where
// valid and ready are both high. Ready is a registered one-cycle pulse raised
// only after the slave has seen the request in idle. A master must hold valid
// (and payload) stable until that transfer edge. The response valid stays high
// until the edge that samples it together with its ready.
`timescale 1ns/1ps

module axi4_lite_register_module (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [6:0]  s_axil_awaddr,
  input  logic [2:0]  s_axil_awprot,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [31:0] s_axil_wdata,
  input  logic [3:0]  s_axil_wstrb,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  output logic [1:0]  s_axil_bresp,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready,
  input  logic [6:0]  s_axil_araddr,
  input  logic [2:0]  s_axil_arprot,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready,
  output logic [31:0] bias_0,
  output logic [31:0] bias_1,
  output logic [31:0] bias_2,
  output logic [31:0] bias_3,
  output logic [31:0] bias_4,
  output logic [31:0] bias_5,
  output logic [31:0] bias_6,
  output logic [31:0] bias_7,
  output logic [31:0] bias_8,
  output logic [31:0] bias_9,
  output logic [31:0] bias_10,
  output logic [31:0] bias_11,
  output logic [31:0] bias_12,
  output logic [31:0] bias_13,
  output logic [31:0] bias_14,
  output logic [31:0] bias_15,
  output logic [31:0] bias_16,
  output logic [31:0] bias_17,
  output logic [31:0] control,
  input  logic [31:0] status
);

  localparam int unsigned NUM_BIAS = 18;
  localparam logic [4:0]  IDX_CONTROL = 5'd18;
  localparam logic [4:0]  IDX_STATUS  = 5'd19;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACCEPT = 2'd1,
    WR_RESP   = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ACCEPT = 2'd1,
    RD_RESP   = 2'd2
  } rd_state_t;

  // Channel states are named signals so checkers can bind to them.
  wr_state_t   wr_state;
  rd_state_t   rd_state;

  logic [31:0] bias_q [NUM_BIAS];
  logic [31:0] control_q;
  logic [4:0]  wr_idx;
  logic [4:0]  rd_idx;
  logic        wr_fire;
  logic        rd_fire;
  logic [31:0] rd_word;
  logic        unused;

  assign wr_idx  = s_axil_awaddr[6:2];
  assign rd_idx  = s_axil_araddr[6:2];
  assign wr_fire = s_axil_awvalid & s_axil_awready & s_axil_wvalid & s_axil_wready;
  assign rd_fire = s_axil_arvalid & s_axil_arready;

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign s_axil_bresp = 2'b00;
  assign s_axil_rresp = 2'b00;

  // Byte-lane merge: lanes with a strobe bit take new data, others keep old.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Write channel: wait for both aw and w, pulse both readies, then hold bvalid.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state       <= WR_IDLE;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (s_axil_awvalid && s_axil_wvalid) begin
            wr_state       <= WR_ACCEPT;
            s_axil_awready <= 1'b1;
            s_axil_wready  <= 1'b1;
          end
        end
        WR_ACCEPT: begin
          s_axil_awready <= 1'b0;
          s_axil_wready  <= 1'b0;
          // A master that withdrew its request gets nothing; start over.
          if (wr_fire) begin
            s_axil_bvalid <= 1'b1;
            wr_state      <= WR_RESP;
          end else begin
            wr_state <= WR_IDLE;
          end
        end
        WR_RESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
            wr_state      <= WR_IDLE;
          end
        end
        default: begin
          wr_state       <= WR_IDLE;
          s_axil_awready <= 1'b0;
          s_axil_wready  <= 1'b0;
          s_axil_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Register storage: byte-merged update on the write transfer edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NUM_BIAS; k++) bias_q[k] <= 32'h0;
      control_q <= 32'h0;
    end else if (wr_fire) begin
      for (int k = 0; k < NUM_BIAS; k++) begin
        if (wr_idx == 5'(k)) bias_q[k] <= merge_bytes(bias_q[k], s_axil_wdata, s_axil_wstrb);
      end
      if (wr_idx == IDX_CONTROL) control_q <= merge_bytes(control_q, s_axil_wdata, s_axil_wstrb);
    end
  end

  // Read decode; status is live, unmapped words read as zero.
  always_comb begin
    rd_word = 32'h0;
    for (int k = 0; k < NUM_BIAS; k++) begin
      if (rd_idx == 5'(k)) rd_word = bias_q[k];
    end
    if (rd_idx == IDX_CONTROL) rd_word = control_q;
    if (rd_idx == IDX_STATUS)  rd_word = status;
  end

  // Read channel: pulse arready, capture rdata on transfer, hold until rready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state       <= RD_IDLE;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= 32'h0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (s_axil_arvalid) begin
            rd_state       <= RD_ACCEPT;
            s_axil_arready <= 1'b1;
          end
        end
        RD_ACCEPT: begin
          s_axil_arready <= 1'b0;
          if (rd_fire) begin
            s_axil_rdata  <= rd_word;
            s_axil_rvalid <= 1'b1;
            rd_state      <= RD_RESP;
          end else begin
            rd_state <= RD_IDLE;
          end
        end
        RD_RESP: begin
          if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
            rd_state      <= RD_IDLE;
          end
        end
        default: begin
          rd_state       <= RD_IDLE;
          s_axil_arready <= 1'b0;
          s_axil_rvalid  <= 1'b0;
        end
      endcase
    end
  end

  assign bias_0  = bias_q[0];
  assign bias_1  = bias_q[1];
  assign bias_2  = bias_q[2];
  assign bias_3  = bias_q[3];
  assign bias_4  = bias_q[4];
  assign bias_5  = bias_q[5];
  assign bias_6  = bias_q[6];
  assign bias_7  = bias_q[7];
  assign bias_8  = bias_q[8];
  assign bias_9  = bias_q[9];
  assign bias_10 = bias_q[10];
  assign bias_11 = bias_q[11];
  assign bias_12 = bias_q[12];
  assign bias_13 = bias_q[13];
  assign bias_14 = bias_q[14];
  assign bias_15 = bias_q[15];
  assign bias_16 = bias_q[16];
  assign bias_17 = bias_q[17];
  assign control = control_q;

endmodule

// File: tb/tb_axi4_lite_register_module.sv
// Directed bench for the AXI4-Lite register file: reset state, bias sweep,
// control/status, byte strobes, handshake back-pressure, unmapped reads and
// asynchronous reset during an outstanding write response.
`timescale 1ns/1ps

module tb_axi4_lite_register_module;

  logic        aclk;
  logic        aresetn;
  logic [6:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [6:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] bias [18];
  logic [31:0] control;
  logic [31:0] status;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  axi4_lite_register_module dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot),
    .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot),
    .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .bias_0(bias[0]), .bias_1(bias[1]), .bias_2(bias[2]), .bias_3(bias[3]),
    .bias_4(bias[4]), .bias_5(bias[5]), .bias_6(bias[6]), .bias_7(bias[7]),
    .bias_8(bias[8]), .bias_9(bias[9]), .bias_10(bias[10]), .bias_11(bias[11]),
    .bias_12(bias[12]), .bias_13(bias[13]), .bias_14(bias[14]), .bias_15(bias[15]),
    .bias_16(bias[16]), .bias_17(bias[17]),
    .control(control), .status(status)
  );

  // Clock and watchdog
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for awready&wready; the pulse should come one edge after request.
  task automatic wait_wr_accept();
    int lat = 0;
    logic seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge aclk); #1;
      lat++;
      if (awready && wready) seen = 1'b1;
    end
    check("aw_w_latency", 32'(lat), 32'd1);
  endtask

  // Pulse bready for one edge and confirm bvalid falls.
  task automatic take_bresp();
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("bvalid_drop", {31'h0, bvalid}, 32'd0);
  endtask

  // Full write; awvalid leads wvalid by 'lead' cycles, bready held off 'hold' cycles.
  task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead, input int hold);
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    for (int i = 0; i < lead; i++) begin
      @(posedge aclk); #1;
      check("aw_only_no_accept", {30'h0, awready, wready}, 32'd0);
    end
    wvalid = 1'b1;
    wait_wr_accept();
    @(posedge aclk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("aw_w_pulse", {30'h0, awready, wready}, 32'd0);
    check("bvalid_rise", {31'h0, bvalid}, 32'd1);
    check("bresp", {30'h0, bresp}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge aclk); #1;
      check("bvalid_hold", {31'h0, bvalid}, 32'd1);
    end
    take_bresp();
  endtask

  // Full read; rready held off 'hold' cycles while rdata must stay put.
  task automatic axi_read(input logic [6:0] addr, input int hold, output logic [31:0] data);
    int lat = 0;
    logic seen = 1'b0;
    araddr  = addr;
    arvalid = 1'b1;
    while (!seen && lat < 20) begin
      @(posedge aclk); #1;
      lat++;
      if (arready) seen = 1'b1;
    end
    check("ar_latency", 32'(lat), 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("arready_pulse", {31'h0, arready}, 32'd0);
    check("rvalid_rise", {31'h0, rvalid}, 32'd1);
    check("rresp", {30'h0, rresp}, 32'd0);
    data = rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge aclk); #1;
      check("rvalid_hold", {31'h0, rvalid}, 32'd1);
      check("rdata_hold", rdata, data);
    end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    check("rvalid_drop", {31'h0, rvalid}, 32'd0);
    check("rdata_keep", rdata, data);
  endtask

  logic [31:0] rd;
  logic [6:0]  a;

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    status = 32'h0;

    // Reset state
    #100;
    for (int k = 0; k < 18; k++) check($sformatf("reset_bias_%0d", k), bias[k], 32'h0);
    check("reset_control", control, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_valids", {27'h0, bvalid, rvalid, awready, wready, arready}, 32'h0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Bias sweep with scoreboard queue
    for (int k = 0; k < 18; k++) begin
      a = 7'(4 * k);
      axi_write(a, 32'h0678 + 32'(k), 4'hF, 0, 0);
      exp_q.push_back(32'h0678 + 32'(k));
      check($sformatf("bias_out_%0d", k), bias[k], 32'h0678 + 32'(k));
      axi_read(a, 0, rd);
      check($sformatf("bias_rd_%0d", k), rd, exp_q.pop_front());
    end

    // Control register
    axi_write(7'h48, 32'h0678, 4'hF, 0, 0);
    check("control_out", control, 32'h0678);
    axi_read(7'h48, 0, rd);
    check("control_rd", rd, 32'h0678);

    // Status: live input, writes ignored
    status = 32'hABCDEF01;
    axi_read(7'h4C, 0, rd);
    check("status_rd", rd, 32'hABCDEF01);
    axi_write(7'h4C, 32'h12345678, 4'hF, 0, 0);
    axi_read(7'h4C, 0, rd);
    check("status_after_wr", rd, 32'hABCDEF01);
    check("control_untouched", control, 32'h0678);
    status = 32'h13572468;
    axi_read(7'h4C, 0, rd);
    check("status_live", rd, 32'h13572468);

    // Byte strobes
    axi_write(7'h08, 32'hFFFFFFFF, 4'hF, 0, 0);
    check("strb_full", bias[2], 32'hFFFFFFFF);
    axi_write(7'h08, 32'h00000000, 4'b0101, 0, 0);
    check("strb_0101", bias[2], 32'hFF00FF00);
    axi_read(7'h08, 0, rd);
    check("strb_rd", rd, 32'hFF00FF00);
    axi_write(7'h0A, 32'hA5A5A5A5, 4'b1000, 0, 0);
    check("strb_1000_addr_lsb_ignored", bias[2], 32'hA500FF00);

    // awvalid three cycles ahead of wvalid
    axi_write(7'h10, 32'hCAFE0004, 4'hF, 3, 0);
    check("aw_lead_bias4", bias[4], 32'hCAFE0004);

    // bready low 5 cycles while a second write waits
    awaddr = 7'h18; wdata = 32'h11110006; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_wr_accept();
    @(posedge aclk); #1;
    check("bp_bvalid_rise", {31'h0, bvalid}, 32'd1);
    check("bp_bias6", bias[6], 32'h11110006);
    awaddr = 7'h1C; wdata = 32'h22220007;
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      check("bp_bvalid_hold", {31'h0, bvalid}, 32'd1);
      check("bp_no_accept", {30'h0, awready, wready}, 32'd0);
      check("bp_bias7_unchanged", bias[7], 32'h0678 + 32'd7);
    end
    take_bresp();
    wait_wr_accept();
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp_second_bvalid", {31'h0, bvalid}, 32'd1);
    take_bresp();
    check("bp_bias7", bias[7], 32'h22220007);
    check("bp_bias6_kept", bias[6], 32'h11110006);

    // rready held low: rvalid/rdata stable
    axi_read(7'h00, 5, rd);
    check("rready_hold_rd", rd, 32'h0678);

    // Unmapped
    axi_read(7'h50, 0, rd);
    check("unmapped_rd", rd, 32'h0);
    axi_write(7'h50, 32'hFFFFFFFF, 4'hF, 0, 0);
    axi_read(7'h50, 0, rd);
    check("unmapped_after_wr", rd, 32'h0);
    check("unmapped_control_kept", control, 32'h0678);

    // Async reset with bvalid high
    awaddr = 7'h0C; wdata = 32'h33330003; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_wr_accept();
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("rst_bvalid_before", {31'h0, bvalid}, 32'd1);
    check("rst_bias3_before", bias[3], 32'h33330003);
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_bvalid_async", {31'h0, bvalid}, 32'd0);
    check("rst_control_async", control, 32'h0);
    check("rst_rdata_async", rdata, 32'h0);
    for (int k = 0; k < 18; k++) check($sformatf("rst_bias_%0d", k), bias[k], 32'h0);
    #20;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("rst_bvalid_after", {31'h0, bvalid}, 32'd0);
    axi_read(7'h0C, 0, rd);
    check("rst_rd_bias3", rd, 32'h0);
    axi_read(7'h48, 0, rd);
    check("rst_rd_control", rd, 32'h0);
    axi_read(7'h44, 0, rd);
    check("rst_rd_bias17", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_lite_register_module.md
# axi4_lite_register_module

AXI4-Lite slave register file exposing the accelerator's configuration to the host CPU. It holds 18 read/write 32-bit bias registers and one read/write control register, and exposes one read-only status word supplied by the datapath. Every register value drives a dedicated output continuously, so the inference core sees writes with no extra protocol.

## Interface
Parameters: none. Widths are fixed: 7-bit address, 32-bit data.

Ports, clock and reset first:
- aclk  in  1  clock; the only clock domain.
- aresetn  in  1  reset; asynchronous, active-low.
- s_axil_awaddr  in  7  write byte address.
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid / s_axil_awready  in / out  1  write-address handshake.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte enables; bit n enables byte n.
- s_axil_wvalid / s_axil_wready  in / out  1  write-data handshake.
- s_axil_bresp  out  2  always 2'b00 (OKAY).
- s_axil_bvalid / s_axil_bready  out / in  1  write-response handshake.
- s_axil_araddr  in  7  read byte address.
- s_axil_arprot  in  3  ignored.
- s_axil_arvalid / s_axil_arready  in / out  1  read-address handshake.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  always 2'b00 (OKAY).
- s_axil_rvalid / s_axil_rready  out / in  1  read-data handshake.
- bias_0 … bias_17  out  32 each  current value of bias register k.
- control  out  32  current value of the control register.
- status  in  32  live status word from the datapath.

## Operation
Address decode uses awaddr[6:2] / araddr[6:2] as the word index; bits [1:0] are ignored.
- Index 0–17 (0x00–0x44): bias_k. Read/write.
- Index 18 (0x48): control. Read/write.
- Index 19 (0x4C): status. Read-only.
  - A read returns the `status` input.
  - Writes complete with OKAY and have no effect.
- Index 20–31: unmapped.
  - Reads return 0.
  - Writes are dropped.
  - Response is OKAY; no SLVERR is ever generated.

Register behaviour:
- Writes merge per byte: each byte lane whose wstrb bit is 1 takes the corresponding wdata byte; other lanes keep their old value.
- Every register resets to 32'h0, so all bias_k, control and s_axil_rdata are 0 after reset.
- Each output port is wired directly to its register (no output stage). Outputs reflect a write on the clock edge that accepts it.

## Timing
Write channel:
- State is idle when bvalid=0 and awready=wready=0.
- In idle, when awvalid and wvalid are both sampled high, awready and wready rise together on the next edge. They are a registered single-cycle pulse.
- The handshake edge is where awvalid&awready&wvalid&wready are all high. At that edge:
  - the addressed register updates;
  - awready and wready drop;
  - bvalid rises.
- bvalid stays high until it is sampled with bready high, then drops.
- No new address/data is accepted while bvalid=1.
- If only one of awvalid/wvalid is high, the slave waits; no partial acceptance.

Read channel:
- State is idle when rvalid=0 and arready=0.
- In idle, when arvalid is sampled high, arready pulses for one cycle on the next edge.
- At the handshake edge:
  - rdata is loaded from the addressed register; status is sampled at this edge;
  - rvalid rises;
  - arready drops.
- rvalid and rdata hold until rvalid&rready is sampled, then rvalid drops. rdata keeps its value.
- No new read is accepted while rvalid=1.

Read and write channels are fully independent and may run concurrently. If a read and a write to the same register complete on the same edge, the read returns the old value.

Reset:
- aresetn low at any time clears all registers and all ready/valid outputs immediately.
- Any in-flight transaction is abandoned without a response.

Latency:
- Write: aw/w valid to bvalid takes 2 edges.
- Read: arvalid to rvalid takes 2 edges.

## Test plan
- Reset check: hold aresetn low for 100 ns. -> All bias_k, control, bvalid, rvalid, awready, wready, arready are 0.
- Bias sweep: for k=0..17, write 32'h0678+k to address 4k, then read it back. -> rdata == 32'h0678+k, bias_k == 32'h0678+k, bresp = rresp = 00.
- Control and status:
  - Write 32'h0678 to 0x48 and read back. -> rdata and control == 32'h0678.
  - With status=32'hABCDEF01, read 0x4C. -> rdata == 32'hABCDEF01.
  - Write 32'h12345678 to 0x4C. -> The next read still returns the status input.
- Byte strobes: write 32'hFFFFFFFF to 0x08, then write 32'h00000000 with wstrb=4'b0101. -> bias_2 == 32'hFF00FF00.
- Handshake stress:
  - Assert awvalid 3 cycles before wvalid. -> No acceptance until both are high.
  - Hold bready low 5 cycles. -> bvalid stays high and a second write is not accepted.
  - Hold rready low. -> rvalid and rdata stay stable.
- Unmapped and async reset:
  - Read 0x50. -> rdata == 0, OKAY.
  - Drop aresetn mid-write with bvalid high. -> bvalid clears immediately and all registers read 0.
